// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with valid/ready handshake and a one-deep skid entry.
// Outputs come straight from the main register; in_ready depends only on registered state.
module pipe_stage_skid #(
  parameter int CTRL_W              = 2,
  parameter int DATA_W              = 69,
  parameter bit ZERO_DATA_ON_BUBBLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      if (ZERO_DATA_ON_BUBBLE) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else if (!main_valid) begin
      // Skid is never occupied while main is empty, so only the input can fill main.
      if (in_fire) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end else begin
        main_ctrl <= '0;
        if (ZERO_DATA_ON_BUBBLE) main_data <= '0;
      end
    end else if (out_fire && skid_valid) begin
      main_ctrl  <= skid_ctrl;
      main_data  <= skid_data;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      if (ZERO_DATA_ON_BUBBLE) skid_data <= '0;
    end else if (out_fire) begin
      if (in_fire) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
        if (ZERO_DATA_ON_BUBBLE) main_data <= '0;
      end
    end else if (in_fire) begin
      // Downstream stalled with main full: park the beat in the skid entry.
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end

endmodule
